// File: rtl/prefetch_queue_if.sv
// Bus types shared by the prefetcher and its environment, plus the interface
// that bundles the redirect, MMU request/response and fetch-side ports.
//   master : prefetcher view (drives MMU request and fetch outputs)
//   slave  : environment view (core + MMU)
package prefetch_pkg;
  typedef enum logic [1:0] {
    BUS_OP_IDLE  = 2'd0,
    BUS_OP_READ  = 2'd1,
    BUS_OP_WRITE = 2'd2
  } bus_op_t;

  typedef enum logic [1:0] {
    BUS_SIZE_BYTE = 2'd0,
    BUS_SIZE_WORD = 2'd1
  } bus_size_t;
endpackage

interface prefetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  // redirect from core
  logic                  redirect_valid;
  logic [15:0]           redirect_addr;
  // MMU side
  logic                  bus_grant;
  prefetch_pkg::bus_op_t   mmu_req_op;
  prefetch_pkg::bus_size_t mmu_req_size;
  logic [15:0]           mmu_req_addr;
  logic                  mmu_resp_done;
  logic [15:0]           mmu_resp_rdata;
  // decode side
  logic                  fetch_valid;
  logic [7:0]            fetch_byte;
  logic [15:0]           fetch_pc;
  logic                  fetch_ready;
  logic [CW-1:0]         queue_count;
  logic                  fetch_busy;

  modport master (
    input  redirect_valid, redirect_addr, bus_grant,
           mmu_resp_done, mmu_resp_rdata, fetch_ready,
    output mmu_req_op, mmu_req_size, mmu_req_addr,
           fetch_valid, fetch_byte, fetch_pc, queue_count, fetch_busy
  );

  modport slave (
    output redirect_valid, redirect_addr, bus_grant,
           mmu_resp_done, mmu_resp_rdata, fetch_ready,
    input  mmu_req_op, mmu_req_size, mmu_req_addr,
           fetch_valid, fetch_byte, fetch_pc, queue_count, fetch_busy
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: streams sequential bytes from fetch_addr over the
// MMU bus into a DEPTH-entry FIFO and offers them to decode via valid/ready.
// A redirect flushes the FIFO and restarts fetching; a read already on the
// bus when the redirect arrives is allowed to finish and its data dropped.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      prefetch_queue_if.master (redirect, MMU req/resp, fetch port,
//            queue_count, fetch_busy)
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0100
) (
  input  logic             clk,
  input  logic             reset_n,
  prefetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        state, state_nxt;
  logic [15:0]   fetch_addr;
  bus_op_t       req_op;
  logic [15:0]   req_addr;
  logic [7:0]    byte_mem [DEPTH];
  logic [15:0]   pc_mem   [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          flush, pop, issue, push, retire;
  logic [7:0]    rdata_unused;

  // upper half of the read data carries nothing for byte fetches
  assign rdata_unused = bus.mmu_resp_rdata[15:8];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // flush wins over a coincident pop
  assign flush = bus.redirect_valid;
  assign pop   = (count != '0) && bus.fetch_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // issue only with a free slot: at most one read is outstanding and pops only
  // free space, so the eventual push always fits
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.bus_grant && (count < DEPTH_C) && !flush) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mmu_resp_done) begin
          retire    = 1'b1;
          push      = !flush;
          state_nxt = S_IDLE;
        end else if (flush) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.mmu_resp_done) begin
          retire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // fetch address and MMU request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr <= RESET_PC;
      req_op     <= BUS_OP_IDLE;
      req_addr   <= 16'h0000;
    end else begin
      if (flush)     fetch_addr <= bus.redirect_addr;
      else if (push) fetch_addr <= fetch_addr + 16'h0001;

      if (issue) begin
        req_op   <= BUS_OP_READ;
        req_addr <= fetch_addr;
      end else if (retire) begin
        req_op   <= BUS_OP_IDLE;
      end
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        byte_mem[i] <= 8'h00;
        pc_mem[i]   <= RESET_PC;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        byte_mem[tail] <= bus.mmu_resp_rdata[7:0];
        pc_mem[tail]   <= req_addr;
        tail           <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // all outputs come straight from state registers
  assign bus.mmu_req_op   = req_op;
  assign bus.mmu_req_size = BUS_SIZE_BYTE;
  assign bus.mmu_req_addr = req_addr;
  assign bus.fetch_valid  = (count != '0);
  assign bus.fetch_byte   = byte_mem[head];
  assign bus.fetch_pc     = pc_mem[head];
  assign bus.queue_count  = count;
  assign bus.fetch_busy   = (state != S_IDLE);

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: MMU model returns addr[7:0] after a
// programmable latency, a monitor logs every pop, and all checks go via chk.
module tb_prefetch_queue;
  import prefetch_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   mmu_lat;
  int   lat_cnt;
  int   reads;
  logic [23:0] pop_q[$];

  prefetch_queue_if #(.DEPTH(4)) bus ();

  prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic quiesce();
    bus.bus_grant = 1'b0;
    for (int i = 0; i < 20 && bus.fetch_busy; i++) cyc(1);
    chk("quiesce", 32'(bus.fetch_busy), 0);
  endtask

  // MMU model: responds lat cycles after the request appears
  initial begin
    bus.mmu_resp_done  = 1'b0;
    bus.mmu_resp_rdata = 16'h0000;
    lat_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mmu_req_op == BUS_OP_READ) begin
        if (lat_cnt >= mmu_lat) begin
          bus.mmu_resp_done  = 1'b1;
          bus.mmu_resp_rdata = {8'hC3, bus.mmu_req_addr[7:0]};
          lat_cnt = 0;
        end else begin
          bus.mmu_resp_done = 1'b0;
          lat_cnt++;
        end
      end else begin
        bus.mmu_resp_done = 1'b0;
        lat_cnt = 0;
      end
    end
  end

  // pop monitor
  always @(negedge clk) begin
    if (reset_n && bus.fetch_valid && bus.fetch_ready && !bus.redirect_valid)
      pop_q.push_back({bus.fetch_pc, bus.fetch_byte});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    mmu_lat = 0;
    reset_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 16'h0000;
    bus.bus_grant      = 1'b0;
    bus.fetch_ready    = 1'b0;

    // reset state
    cyc(3);
    chk("rst_op",    32'(bus.mmu_req_op), 32'(BUS_OP_IDLE));
    chk("rst_size",  32'(bus.mmu_req_size), 32'(BUS_SIZE_BYTE));
    chk("rst_addr",  32'(bus.mmu_req_addr), 0);
    chk("rst_valid", 32'(bus.fetch_valid), 0);
    chk("rst_byte",  32'(bus.fetch_byte), 0);
    chk("rst_pc",    32'(bus.fetch_pc), 32'h0100);
    chk("rst_cnt",   32'(bus.queue_count), 0);
    chk("rst_busy",  32'(bus.fetch_busy), 0);

    // zero-wait fill to DEPTH
    bus.bus_grant = 1'b1;
    reset_n = 1'b1;
    cyc(1);
    chk("fill_op0",   32'(bus.mmu_req_op), 32'(BUS_OP_READ));
    chk("fill_addr0", 32'(bus.mmu_req_addr), 32'h0100);
    chk("fill_busy0", 32'(bus.fetch_busy), 1);
    chk("fill_vld0",  32'(bus.fetch_valid), 0);
    cyc(1);
    chk("fill_vld1",  32'(bus.fetch_valid), 1);
    chk("fill_byte1", 32'(bus.fetch_byte), 32'h00);
    chk("fill_pc1",   32'(bus.fetch_pc), 32'h0100);
    chk("fill_op1",   32'(bus.mmu_req_op), 32'(BUS_OP_IDLE));
    cyc(10);
    chk("full_cnt",  32'(bus.queue_count), 4);
    chk("full_op",   32'(bus.mmu_req_op), 32'(BUS_OP_IDLE));
    chk("full_busy", 32'(bus.fetch_busy), 0);
    chk("full_pc",   32'(bus.fetch_pc), 32'h0100);

    // continuous drain: in-order, none lost or duplicated
    pop_q.delete();
    bus.fetch_ready = 1'b1;
    cyc(40);
    bus.fetch_ready = 1'b0;
    chk("stream_cnt_ge20", 32'(pop_q.size() >= 20), 1);
    for (int i = 0; i < pop_q.size(); i++) begin
      chk("stream_pc",   32'(pop_q[i][23:8]), 32'h0100 + i);
      chk("stream_byte", 32'(pop_q[i][7:0]), i & 32'hFF);
    end

    // 3-cycle MMU, redirect during WAIT drops the late byte
    quiesce();
    mmu_lat = 2;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 16'h1055;
    cyc(1);
    bus.redirect_valid = 1'b0;
    chk("rd1_cnt", 32'(bus.queue_count), 0);
    chk("rd1_vld", 32'(bus.fetch_valid), 0);
    bus.bus_grant = 1'b1;
    cyc(1);
    chk("rd2_op",   32'(bus.mmu_req_op), 32'(BUS_OP_READ));
    chk("rd2_addr", 32'(bus.mmu_req_addr), 32'h1055);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 16'h2000;
    cyc(1);
    bus.redirect_valid = 1'b0;
    chk("disc_busy", 32'(bus.fetch_busy), 1);
    chk("disc_op",   32'(bus.mmu_req_op), 32'(BUS_OP_READ));
    chk("disc_addr", 32'(bus.mmu_req_addr), 32'h1055);
    cyc(2);
    chk("disc_done_op",  32'(bus.mmu_req_op), 32'(BUS_OP_IDLE));
    chk("disc_done_cnt", 32'(bus.queue_count), 0);
    chk("disc_done_vld", 32'(bus.fetch_valid), 0);
    cyc(1);
    chk("redir_op",   32'(bus.mmu_req_op), 32'(BUS_OP_READ));
    chk("redir_addr", 32'(bus.mmu_req_addr), 32'h2000);
    cyc(3);
    chk("redir_vld",  32'(bus.fetch_valid), 1);
    chk("redir_pc",   32'(bus.fetch_pc), 32'h2000);
    chk("redir_byte", 32'(bus.fetch_byte), 32'h00);
    chk("redir_cnt",  32'(bus.queue_count), 1);

    // address wrap FFFF -> 0000
    quiesce();
    mmu_lat = 0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 16'hFFFE;
    cyc(1);
    bus.redirect_valid = 1'b0;
    pop_q.delete();
    bus.bus_grant = 1'b1;
    cyc(12);
    chk("wrap_cnt",  32'(bus.queue_count), 4);
    chk("wrap_pc0",  32'(bus.fetch_pc), 32'hFFFE);
    chk("wrap_byte", 32'(bus.fetch_byte), 32'hFE);
    bus.fetch_ready = 1'b1;
    cyc(4);
    bus.fetch_ready = 1'b0;
    chk("wrap_pops", 32'(pop_q.size() >= 4), 1);
    if (pop_q.size() >= 4) begin
      chk("wrap_p0", 32'(pop_q[0]), 32'hFFFEFE);
      chk("wrap_p1", 32'(pop_q[1]), 32'hFFFFFF);
      chk("wrap_p2", 32'(pop_q[2]), 32'h000000);
      chk("wrap_p3", 32'(pop_q[3]), 32'h000101);
    end

    // grant low: no new issue, in-flight read still completes
    quiesce();
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 16'h0040;
    cyc(1);
    bus.redirect_valid = 1'b0;
    mmu_lat = 2;
    bus.bus_grant = 1'b1;
    cyc(1);
    chk("gnt_op",   32'(bus.mmu_req_op), 32'(BUS_OP_READ));
    chk("gnt_addr", 32'(bus.mmu_req_addr), 32'h0040);
    bus.bus_grant = 1'b0;
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus.mmu_req_op == BUS_OP_READ) reads++;
    end
    chk("gnt_reads", 32'(reads), 2);
    chk("gnt_cnt",   32'(bus.queue_count), 1);
    chk("gnt_byte",  32'(bus.fetch_byte), 32'h40);
    chk("gnt_pc",    32'(bus.fetch_pc), 32'h0040);
    chk("gnt_busy",  32'(bus.fetch_busy), 0);

    // reset asserted mid-WAIT
    bus.bus_grant = 1'b1;
    cyc(1);
    chk("mid_op",   32'(bus.mmu_req_op), 32'(BUS_OP_READ));
    chk("mid_addr", 32'(bus.mmu_req_addr), 32'h0041);
    reset_n = 1'b0;
    #1;
    chk("mrst_op",    32'(bus.mmu_req_op), 32'(BUS_OP_IDLE));
    chk("mrst_addr",  32'(bus.mmu_req_addr), 0);
    chk("mrst_busy",  32'(bus.fetch_busy), 0);
    chk("mrst_cnt",   32'(bus.queue_count), 0);
    chk("mrst_vld",   32'(bus.fetch_valid), 0);
    chk("mrst_pc",    32'(bus.fetch_pc), 32'h0100);
    chk("mrst_byte",  32'(bus.fetch_byte), 0);
    mmu_lat = 0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    chk("post_op",   32'(bus.mmu_req_op), 32'(BUS_OP_READ));
    chk("post_addr", 32'(bus.mmu_req_addr), 32'h0100);
    cyc(1);
    chk("post_vld",  32'(bus.fetch_valid), 1);
    chk("post_pc",   32'(bus.fetch_pc), 32'h0100);
    chk("post_byte", 32'(bus.fetch_byte), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
